ysyx_25020037_uart_tx_fifo: RTL and testbench

//  AXI4-Lite slave UART transmitter. Sits downstream of ysyx_25020037_axi_crossbar on a peripheral port.

---
 rtl/ysyx_25020037_uart_tx_fifo.sv | 272 +++++++++++++++++++++++++++
 tb/tb_ysyx_25020037_uart_tx_fifo.sv | 559 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25020037_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// ysyx_25020037_uart_tx_fifo
//   AXI4-Lite slave UART transmitter on a peripheral port of the crossbar.
//   Byte writes to TXDATA are queued in a TX FIFO and sent on txd_o as 8N1
//   frames. The bit time comes from the programmable BAUDDIV register.
//   STATUS lets software poll full/empty/busy instead of stalling the core.
//
//   Register map (offset [3:0]):
//     0x0 TXDATA   W: push wdata[7:0] when wstrb[0]; R: 0
//     0x4 STATUS   R: {29'b0, busy, empty, full}; W: ignored (OKAY)
//     0x8 BAUDDIV  RW: [15:0], byte lanes per wstrb[1:0], 0 stored as 1
//     others       R: 0 / SLVERR; W: no effect / SLVERR
//
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   araddr_i/arvalid_i/arready_o  read address channel
//   rdata_o/rresp_o/rvalid_o/rready_i  read data channel
//   awaddr_i/awvalid_i/awready_o  write address channel
//   wdata_i/wstrb_i/wvalid_i/wready_o  write data channel
//   bresp_o/bvalid_o/bready_i     write response channel
//   txd_o                         serial output, idle high
//   tx_idle_o                     FIFO empty and transmitter idle
// ---------------------------------------------------------------------------
module ysyx_25020037_uart_tx_fifo #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd868
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] araddr_i,
  input  logic        arvalid_i,
  output logic        arready_o,
  output logic [31:0] rdata_o,
  output logic [1:0]  rresp_o,
  output logic        rvalid_o,
  input  logic        rready_i,
  input  logic [31:0] awaddr_i,
  input  logic        awvalid_i,
  output logic        awready_o,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  input  logic        wvalid_i,
  output logic        wready_o,
  output logic [1:0]  bresp_o,
  output logic        bvalid_o,
  input  logic        bready_i,
  output logic        txd_o,
  output logic        tx_idle_o
);

  localparam int unsigned PW        = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_CNT = (PW+1)'(FIFO_DEPTH);

  localparam logic [3:0] ADDR_TXDATA  = 4'h0;
  localparam logic [3:0] ADDR_STATUS  = 4'h4;
  localparam logic [3:0] ADDR_BAUDDIV = 4'h8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } txState_e;

  // FIFO storage and pointers; the extra pointer bit separates full from empty
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [PW:0] wrPtr_q, rdPtr_q;
  logic [PW:0] count;
  logic        full, empty;
  logic        push, pop;

  // Register file and AXI response state
  logic [15:0] baudDiv_q, baudDiv_d;
  logic        rvalid_q;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        bvalid_q;
  logic [1:0]  bresp_q, bresp_d;

  // Transmitter state
  txState_e    state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [15:0] divLat_q, divLat_d;
  logic [2:0]  bitIdx_q, bitIdx_d;
  logic [7:0]  shift_q, shift_d;
  logic        txd;
  logic        busy;

  logic [3:0]  awOff;
  logic        stall;
  logic        wrHs;
  logic        arHs;

  // Upper address/data bits and the high strobes are not decoded
  logic unused_ok;
  assign unused_ok = ^{araddr_i[31:4], awaddr_i[31:4], wdata_i[31:16], wstrb_i[3:2]};

  assign count = wrPtr_q - rdPtr_q;
  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);
  assign busy  = (state_q != TX_IDLE);

  // A TXDATA push into a full FIFO holds off both AW and W so nothing is lost
  assign awOff     = awaddr_i[3:0];
  assign stall     = (awOff == ADDR_TXDATA) & wstrb_i[0] & full;
  assign wrHs      = awvalid_i & wvalid_i & ~bvalid_q & ~stall;
  assign awready_o = wrHs;
  assign wready_o  = wrHs;
  assign push      = wrHs & (awOff == ADDR_TXDATA) & wstrb_i[0];

  assign arHs      = arvalid_i & ~rvalid_q;
  assign arready_o = ~rvalid_q;

  assign rvalid_o  = rvalid_q;
  assign rdata_o   = rdata_q;
  assign rresp_o   = rresp_q;
  assign bvalid_o  = bvalid_q;
  assign bresp_o   = bresp_q;
  assign txd_o     = txd;
  assign tx_idle_o = empty & ~busy;

  // Read decode; captured into rdata_q on the AR handshake
  always_comb begin
    rdata_d = '0;
    rresp_d = RESP_OKAY;
    case (araddr_i[3:0])
      ADDR_TXDATA:  rdata_d = '0;
      ADDR_STATUS:  rdata_d = {29'b0, busy, empty, full};
      ADDR_BAUDDIV: rdata_d = {16'b0, baudDiv_q};
      default:      rresp_d = RESP_SLVERR;
    endcase
  end

  // BAUDDIV lane merge; a zero divider would never advance, so it becomes 1
  always_comb begin
    baudDiv_d = baudDiv_q;
    if (wstrb_i[0]) baudDiv_d[7:0]  = wdata_i[7:0];
    if (wstrb_i[1]) baudDiv_d[15:8] = wdata_i[15:8];
    if (baudDiv_d == 16'd0) baudDiv_d = 16'd1;
  end

  always_comb begin
    case (awOff)
      ADDR_TXDATA, ADDR_STATUS, ADDR_BAUDDIV: bresp_d = RESP_OKAY;
      default:                                bresp_d = RESP_SLVERR;
    endcase
  end

  // Read channel: one outstanding read, data held until rready
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (arHs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end else if (rready_i) begin
      rvalid_q <= 1'b0;
    end
  end

  // Write response and BAUDDIV update on the AW/W handshake edge
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      baudDiv_q <= DIV_RESET;
    end else begin
      if (wrHs) begin
        bvalid_q <= 1'b1;
        bresp_q  <= bresp_d;
        if (awOff == ADDR_BAUDDIV) baudDiv_q <= baudDiv_d;
      end else if (bready_i) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  // FIFO pointers; push and pop in one cycle both advance
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + 1'b1;
      if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
    end
  end

  // Storage needs no reset; the pointers define what is valid
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wrPtr_q[PW-1:0]] <= wdata_i[7:0];
  end

  // Transmitter state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= TX_IDLE;
      timer_q  <= '0;
      divLat_q <= DIV_RESET;
      bitIdx_q <= '0;
      shift_q  <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      divLat_q <= divLat_d;
      bitIdx_q <= bitIdx_d;
      shift_q  <= shift_d;
    end
  end

  // Frame sequencing; the divider is latched at frame start so BAUDDIV
  // writes during a frame only affect the following one
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    divLat_d = divLat_q;
    bitIdx_d = bitIdx_q;
    shift_d  = shift_q;
    pop      = 1'b0;
    txd      = 1'b1;
    case (state_q)
      TX_IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          shift_d  = mem_q[rdPtr_q[PW-1:0]];
          divLat_d = baudDiv_q;
          timer_d  = baudDiv_q - 16'd1;
          state_d  = TX_START;
        end
      end
      TX_START: begin
        txd = 1'b0;
        if (timer_q == 16'd0) begin
          state_d  = TX_DATA;
          bitIdx_d = 3'd0;
          timer_d  = divLat_q - 16'd1;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      TX_DATA: begin
        txd = shift_q[0];
        if (timer_q == 16'd0) begin
          timer_d = divLat_q - 16'd1;
          if (bitIdx_q == 3'd7) begin
            state_d = TX_STOP;
          end else begin
            shift_d  = {1'b0, shift_q[7:1]};
            bitIdx_d = bitIdx_q + 3'd1;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      TX_STOP: begin
        if (timer_q == 16'd0) begin
          state_d = TX_IDLE;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ysyx_25020037_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_ysyx_25020037_uart_tx_fifo
//   Self-checking bench for the AXI4-Lite UART transmitter. A free-running
//   UART receiver decodes txd at mid-bit into a queue, and each test compares
//   decoded bytes and register reads against values kept by the bench.
// ---------------------------------------------------------------------------
module tb_ysyx_25020037_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic        txd;
  logic        tx_idle;

  int checks   = 0;
  int failures = 0;

  // Bench-side view of BAUDDIV
  logic [15:0] modelDiv;

  // Receiver state
  int          rxDiv = 868;
  bit          rxActive = 1'b0;
  int          rxCnt = 0;
  logic [7:0]  rxByte = '0;
  int          rxFrameErr = 0;
  logic [7:0]  rxQ[$];

  ysyx_25020037_uart_tx_fifo #(
    .FIFO_DEPTH(8),
    .DIV_RESET (16'd868)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .araddr_i (araddr),
    .arvalid_i(arvalid),
    .arready_o(arready),
    .rdata_o  (rdata),
    .rresp_o  (rresp),
    .rvalid_o (rvalid),
    .rready_i (rready),
    .awaddr_i (awaddr),
    .awvalid_i(awvalid),
    .awready_o(awready),
    .wdata_i  (wdata),
    .wstrb_i  (wstrb),
    .wvalid_i (wvalid),
    .wready_o (wready),
    .bresp_o  (bresp),
    .bvalid_o (bvalid),
    .bready_i (bready),
    .txd_o    (txd),
    .tx_idle_o(tx_idle)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Mid-bit UART receiver: frame start is the first low sample, each bit is
  // sampled rxDiv/2 cycles into its slot
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      rxActive <= 1'b0;
    end else if (!rxActive) begin
      if (txd === 1'b0) begin
        rxActive <= 1'b1;
        rxCnt    <= 1;
        rxByte   <= '0;
      end
    end else begin
      rxCnt <= rxCnt + 1;
      if (rxCnt == rxDiv / 2 && txd !== 1'b0) rxFrameErr <= rxFrameErr + 1;
      if (rxCnt >= rxDiv + rxDiv / 2 && rxCnt < 9 * rxDiv &&
          ((rxCnt - rxDiv - rxDiv / 2) % rxDiv) == 0)
        rxByte[(rxCnt - rxDiv - rxDiv / 2) / rxDiv] <= txd;
      if (rxCnt == 9 * rxDiv + rxDiv / 2) begin
        if (txd !== 1'b1) rxFrameErr <= rxFrameErr + 1;
        rxQ.push_back(rxByte);
        rxActive <= 1'b0;
      end
    end
  end

  function automatic logic [15:0] mergeDiv(input logic [15:0] old,
                                           input logic [31:0] d,
                                           input logic [3:0] s);
    logic [15:0] r;
    r = old;
    if (s[0]) r[7:0]  = d[7:0];
    if (s[1]) r[15:8] = d[15:8];
    if (r == 16'd0) r = 16'd1;
    return r;
  endfunction

  task automatic axiWrite(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [1:0] resp,
                          output int waitCycles);
    int n;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    waitCycles = 0;
    #1;
    while (awready !== 1'b1 && waitCycles < 5000) begin
      @(negedge clk);
      #1;
      waitCycles++;
    end
    if (awready !== 1'b1) begin
      checks++; failures++;
      $display("[TB] FAIL write_accept addr=%h got awready=%b want 1", a, awready);
      awvalid = 1'b0; wvalid = 1'b0; resp = 2'bxx;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (bvalid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bvalid !== 1'b1) begin
      checks++; failures++;
      $display("[TB] FAIL write_bvalid addr=%h got bvalid=%b want 1", a, bvalid);
    end
    resp = bresp;
    @(posedge clk);
    #1;
  endtask

  task automatic axiRead(input logic [31:0] a, output logic [31:0] d,
                         output logic [1:0] resp);
    int n;
    @(negedge clk);
    araddr = a; arvalid = 1'b1; rready = 1'b0;
    #1;
    n = 0;
    while (arready !== 1'b1 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0;
    n = 0;
    while (rvalid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (rvalid !== 1'b1) begin
      checks++; failures++;
      $display("[TB] FAIL read_rvalid addr=%h got rvalid=%b want 1", a, rvalid);
    end
    d = rdata; resp = rresp;
    rready = 1'b1;
    @(posedge clk);
    #1;
    rready = 1'b0;
  endtask

  // Waits until the receiver has `want` bytes and the transmitter is idle
  task automatic waitDrain(input int want, input int limit);
    int n;
    n = 0;
    while ((rxQ.size() < want || tx_idle !== 1'b1) && n < limit) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rxQ.size() != want || tx_idle !== 1'b1) begin
      failures++;
      $display("[TB] FAIL drain got bytes=%0d tx_idle=%b want bytes=%0d tx_idle=1",
               rxQ.size(), tx_idle, want);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [1:0]  r;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({txd, tx_idle, rvalid, bvalid} !== 4'b1100) begin
      failures++;
      $display("[TB] FAIL reset_flags got txd/idle/rvalid/bvalid=%b want 1100",
               {txd, tx_idle, rvalid, bvalid});
    end
    checks++;
    if ({rdata, rresp, bresp} !== 36'd0) begin
      failures++;
      $display("[TB] FAIL reset_regs got rdata=%h rresp=%b bresp=%b want 0",
               rdata, rresp, bresp);
    end
    rst_n = 1'b1;
    modelDiv = 16'd868;
    rxDiv = 868;
    #1;
    checks++;
    if (arready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_arready got=%b want=1", arready);
    end
    axiRead(32'h8, d, r);
    checks++;
    if (d !== 32'd868 || r !== 2'b00) begin
      failures++;
      $display("[TB] FAIL reset_bauddiv got=%0d/%b want=868/00", d, r);
    end
    axiRead(32'h4, d, r);
    checks++;
    if (d !== 32'h2 || r !== 2'b00) begin
      failures++;
      $display("[TB] FAIL reset_status got=%h/%b want=2/00", d, r);
    end
  endtask

  task automatic test_single_frame();
    logic [1:0] r;
    int         w, n, bad, badCycle;
    logic [9:0] frame;
    logic       exp, badGot;
    axiWrite(32'h8, 32'd4, 4'b0011, r, w);
    modelDiv = 16'd4;
    rxDiv = 4;
    rxQ.delete();
    axiWrite(32'h0, 32'h0000_00A5, 4'b0001, r, w);
    checks++;
    if (r !== 2'b00) begin
      failures++;
      $display("[TB] FAIL frame_bresp got=%b want=00", r);
    end
    frame = {1'b1, 8'hA5, 1'b0};
    n = 0;
    @(negedge clk);
    while (txd !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    bad = 0; badCycle = 0; badGot = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clk);
      exp = frame[c / 4];
      if (txd !== exp) begin
        if (bad == 0) begin badCycle = c; badGot = txd; end
        bad++;
      end
      if (c == 39) begin
        checks++;
        if (tx_idle !== 1'b0) begin
          failures++;
          $display("[TB] FAIL frame_idle_in_stop got=%b want=0", tx_idle);
        end
      end
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("[TB] FAIL frame_waveform cycle=%0d got=%b want=%b (%0d bad cycles)",
               badCycle, badGot, frame[badCycle / 4], bad);
    end
    @(negedge clk);
    checks++;
    if (tx_idle !== 1'b1 || txd !== 1'b1) begin
      failures++;
      $display("[TB] FAIL frame_after_stop got tx_idle=%b txd=%b want 1 1", tx_idle, txd);
    end
    checks++;
    if (rxQ.size() != 1 || rxQ[0] !== 8'hA5) begin
      failures++;
      $display("[TB] FAIL frame_rx got count=%0d want count=1 byte=a5", rxQ.size());
    end
  endtask

  task automatic test_fifo_full();
    logic [1:0]  r;
    logic [31:0] d;
    int          w, stalledEarly;
    logic [7:0]  expQ[$];
    logic [7:0]  b;
    rxQ.delete();
    stalledEarly = 0;
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom);
      expQ.push_back(b);
      axiWrite(32'h0, {24'h0, b}, 4'b0001, r, w);
      if (w != 0) stalledEarly++;
    end
    checks++;
    if (stalledEarly != 0) begin
      failures++;
      $display("[TB] FAIL full_early_stall got=%0d stalled writes want=0", stalledEarly);
    end
    axiRead(32'h4, d, r);
    checks++;
    if (d !== 32'h5) begin
      failures++;
      $display("[TB] FAIL full_status got=%h want=5", d);
    end
    b = 8'($urandom);
    expQ.push_back(b);
    axiWrite(32'h0, {24'h0, b}, 4'b0001, r, w);
    checks++;
    if (w == 0) begin
      failures++;
      $display("[TB] FAIL full_stall got wait=%0d cycles want >0", w);
    end
    waitDrain(expQ.size(), 2000);
    for (int i = 0; i < expQ.size(); i++) begin
      checks++;
      if (i >= rxQ.size() || rxQ[i] !== expQ[i]) begin
        failures++;
        $display("[TB] FAIL full_order idx=%0d got=%h want=%h", i,
                 (i < rxQ.size()) ? rxQ[i] : 8'hxx, expQ[i]);
      end
    end
  endtask

  task automatic test_bad_offset();
    logic [1:0]  r;
    logic [31:0] d, a, rnd;
    int          w;
    logic [3:0]  off;
    axiWrite(32'hC, $urandom, 4'b1111, r, w);
    checks++;
    if (r !== 2'b10) begin
      failures++;
      $display("[TB] FAIL bad_bresp got=%b want=10", r);
    end
    axiRead(32'hC, d, r);
    checks++;
    if (r !== 2'b10 || d !== 32'd0) begin
      failures++;
      $display("[TB] FAIL bad_read got=%h/%b want=0/10", d, r);
    end
    do off = 4'($urandom); while (off == 4'h0 || off == 4'h4 || off == 4'h8);
    rnd = $urandom;
    a = {rnd[31:4], off};
    axiWrite(a, $urandom, 4'b0011, r, w);
    checks++;
    if (r !== 2'b10) begin
      failures++;
      $display("[TB] FAIL bad_rand_bresp addr=%h got=%b want=10", a, r);
    end
    axiWrite(32'h4, 32'hFFFF_FFFF, 4'b1111, r, w);
    checks++;
    if (r !== 2'b00) begin
      failures++;
      $display("[TB] FAIL status_write_bresp got=%b want=00", r);
    end
    axiRead(32'h8, d, r);
    checks++;
    if (d !== {16'h0, modelDiv} || r !== 2'b00) begin
      failures++;
      $display("[TB] FAIL bad_nochange_div got=%h want=%h", d, modelDiv);
    end
    axiRead(32'h4, d, r);
    checks++;
    if (d !== 32'h2) begin
      failures++;
      $display("[TB] FAIL bad_nochange_status got=%h want=2", d);
    end
    axiRead(32'h0, d, r);
    checks++;
    if (d !== 32'h0 || r !== 2'b00) begin
      failures++;
      $display("[TB] FAIL txdata_read got=%h/%b want=0/00", d, r);
    end
  endtask

  task automatic test_bauddiv();
    logic [1:0]  r;
    logic [31:0] d, held;
    int          w, badHold;
    axiWrite(32'h8, 32'h0, 4'b0011, r, w);
    modelDiv = mergeDiv(modelDiv, 32'h0, 4'b0011);
    axiRead(32'h8, d, r);
    checks++;
    if (d !== 32'd1) begin
      failures++;
      $display("[TB] FAIL div_zero got=%0d want=1", d);
    end
    axiWrite(32'h8, 32'h1234, 4'b0001, r, w);
    modelDiv = mergeDiv(modelDiv, 32'h1234, 4'b0001);
    axiWrite(32'h8, 32'hAB00, 4'b0010, r, w);
    modelDiv = mergeDiv(modelDiv, 32'hAB00, 4'b0010);
    axiWrite(32'h8, 32'h0, 4'b0001, r, w);
    modelDiv = mergeDiv(modelDiv, 32'h0, 4'b0001);
    // Hold rready low and watch the read data stay put
    @(negedge clk);
    araddr = 32'h8; arvalid = 1'b1; rready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0;
    araddr = 32'h4;
    badHold = 0;
    held = rdata;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (rvalid !== 1'b1 || arready !== 1'b0 || rdata !== held) badHold++;
      @(negedge clk);
    end
    checks++;
    if (held !== {16'h0, modelDiv}) begin
      failures++;
      $display("[TB] FAIL div_lanes got=%h want=%h", held, modelDiv);
    end
    checks++;
    if (badHold != 0) begin
      failures++;
      $display("[TB] FAIL read_hold got %0d unstable cycles want=0", badHold);
    end
    rready = 1'b1;
    @(posedge clk);
    #1;
    rready = 1'b0;
    checks++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL read_release got rvalid=%b arready=%b want 0 1", rvalid, arready);
    end
  endtask

  task automatic test_random_stream();
    logic [1:0]  r;
    logic [3:0]  s;
    logic [31:0] d;
    int          w, n, div;
    logic [7:0]  expQ[$];
    for (int round = 0; round < 3; round++) begin
      div = $urandom_range(2, 5);
      axiWrite(32'h8, div, 4'b0011, r, w);
      modelDiv = 16'(div);
      rxDiv = div;
      rxQ.delete();
      expQ.delete();
      n = $urandom_range(3, 12);
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        d = $urandom;
        s = 4'($urandom);
        if ($urandom_range(0, 3) != 0) s[0] = 1'b1;
        if (s[0]) expQ.push_back(d[7:0]);
        axiWrite(32'h0, d, s, r, w);
      end
      waitDrain(expQ.size(), 14 * 10 * div + 200);
      for (int i = 0; i < expQ.size(); i++) begin
        checks++;
        if (i >= rxQ.size() || rxQ[i] !== expQ[i]) begin
          failures++;
          $display("[TB] FAIL stream round=%0d idx=%0d got=%h want=%h", round, i,
                   (i < rxQ.size()) ? rxQ[i] : 8'hxx, expQ[i]);
        end
      end
    end
    checks++;
    if (rxFrameErr != 0) begin
      failures++;
      $display("[TB] FAIL frame_errors got=%0d want=0", rxFrameErr);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [1:0]  r;
    logic [31:0] d;
    int          w, n, rose;
    axiWrite(32'h8, 32'd4, 4'b0011, r, w);
    modelDiv = 16'd4;
    rxDiv = 4;
    axiWrite(32'h0, 32'h00, 4'b0001, r, w);
    axiWrite(32'h0, 32'h00, 4'b0001, r, w);
    n = 0;
    while (txd !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (6) @(negedge clk);
    checks++;
    if (txd !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mid_data_level got=%b want=0", txd);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (txd !== 1'b1 || tx_idle !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_abort got txd=%b tx_idle=%b want 1 1", txd, tx_idle);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    modelDiv = 16'd868;
    rxDiv = 868;
    rxQ.delete();
    axiRead(32'h4, d, r);
    checks++;
    if (d !== 32'h2) begin
      failures++;
      $display("[TB] FAIL reset_mid_status got=%h want=2", d);
    end
    axiRead(32'h8, d, r);
    checks++;
    if (d !== 32'd868) begin
      failures++;
      $display("[TB] FAIL reset_mid_div got=%0d want=868", d);
    end
    rose = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) rose++;
    end
    checks++;
    if (rose != 0) begin
      failures++;
      $display("[TB] FAIL reset_flush got %0d low cycles want=0", rose);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b1;
    modelDiv = 16'd868;
    $display("[TB] starting");
    test_reset();
    test_single_frame();
    test_fifo_full();
    test_bad_offset();
    test_bauddiv();
    test_random_stream();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
